tx_corr_sched: RTL
==================

Name: tx_corr_sched

Overview:
- Sits on the settings bus between the host/CPU settings master and a tx_frontend instance at the same BASE.
- Host writes to the four correction registers (I/Q DC offset, magnitude, phase) are intercepted and stored as targets. The block then ramps the live values toward those targets in bounded steps, so corrections change without spurs.
- All other host writes pass straight through. Host traffic always has priority over ramp writes on the downstream bus.

Parameters:
- BASE, 0, settings address of tx_frontend register 0; the block owns BASE+0..BASE+3 and BASE+6
- DCO_W, 24, width of DC offset registers (BASE+0, BASE+1)
- CORR_W, 18, width of magnitude/phase registers (BASE+2, BASE+3)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_stb  in  1  host settings strobe
- in_addr  in  8  host settings address
- in_data  in  32  host settings data
- out_stb  out  1  downstream settings strobe to tx_frontend
- out_addr  out  8  downstream address
- out_data  out  32  downstream data; sign-extended value for correction registers
- busy  out  1  high while any channel has current != target

Behaviour:
- Reset (rst low, asynchronous): out_stb=0, out_addr=0, out_data=0, busy=0; all targets, currents and pending flags=0; interval=0, step=0; FSM to IDLE.
- Control register BASE+6 is absorbed, never forwarded: [15:0] interval, [31:16] step (unsigned).
- Host write to BASE+0..3: target[ch] <= in_data sign-truncated to DCO_W or CORR_W; not forwarded; current unchanged. A new target mid-ramp replaces the old one, and the next step heads toward the new target.
- Any other host write is forwarded with 1-cycle latency: registered out_stb/out_addr/out_data. A host strobe in cycle N always produces out_stb in cycle N+1.
- Tick counter: free-runs modulo interval+1. On each tick, pending[ch] is set for every ch with current != target.
- FSM:
  - IDLE -> SCAN when any pending.
  - SCAN picks the lowest-numbered pending ch at or after the round-robin pointer (wrap 3->0), then -> ISSUE.
  - ISSUE waits for a cycle with no host strobe on in_stb. In that cycle it:
    - computes the next value: if step==0 or |target-current|<=step, next=target; else next=current±step.
    - updates current[ch], drives out_stb=1, out_addr=BASE+ch, out_data=sign-extended next.
    - clears pending[ch], advances the pointer to ch+1, then -> IDLE if no pending, else SCAN.
- Arithmetic: signed, computed in DCO_W+1 bits. The result is clamped to target, so it never overshoots and never wraps.
- At most one downstream write per cycle; a host write and a ramp write never collide. A ramp write is stalled indefinitely under continuous host strobes; ticks that elapse meanwhile coalesce (pending is a flag, not a count).
- busy is registered: it is high from the cycle after a target differs from current until the cycle after the final write.
- Writing BASE+6 mid-ramp takes effect at the next tick boundary; the tick counter restarts at 0.

Optional Feature:
- TX_CORR_RAMP_EN defined: ramping behaves as above.
- Undefined: step field ignored, treated as 0; tick counter removed. Any target write sets pending immediately, so each target write causes exactly one downstream write of the full value, still arbitrated behind host traffic.

Decomposition:
- Shared package tx_corr_pkg holds:
  - channel index constants CH_IDCO=0, CH_QDCO=1, CH_MAG=2, CH_PHASE=3
  - control offset CTRL_OFS=6
  - FSM state encoding IDLE/SCAN/ISSUE
- One sub-module: tx_corr_step, combinational next-value-with-clamp for one channel (signed compare, ±step, clamp). Instantiated once and muxed by the selected channel.

Test Plan:
- Pass-through: host write addr BASE+4, data 0x11 -> out_stb=1 next cycle with addr BASE+4, data 0x11; no other downstream write.
- Ramp up: ctrl step=0x100, interval=3; target I_DCO=0x000300 -> three writes 0x100, 0x200, 0x300 on addr BASE+0, ticks 4 cycles apart; busy falls after the third write.
- Clamp/negative: current PHASE=0, step=0x40, target=-0x50 (18-bit) -> writes 0x3FFC0 then 0x3FFB0 (sign-extended in out_data); no overshoot.
- Arbitration: hold in_stb high to non-correction addresses for 10 cycles while pending -> only forwarded writes appear; the ramp write appears in the first host-idle cycle; no lost host writes.
- Round-robin/retarget: set targets on all four channels, step=0, interval=0 -> writes ordered ch0,1,2,3. Retarget ch1 mid-sequence -> ch1's next write carries the new value.
- Reset mid-ramp: assert rst during ISSUE -> outputs 0 immediately (async). After release, no downstream write occurs until a new target write.

Source files
------------

// File: rtl/tx_corr_pkg.sv
// Shared definitions for the tx_frontend correction scheduler: channel indices,
// control register offset, scheduler states and the round-robin pick helper.
package tx_corr_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] CH_IDCO  = 2'd0;
    localparam logic [1:0] CH_QDCO  = 2'd1;
    localparam logic [1:0] CH_MAG   = 2'd2;
    localparam logic [1:0] CH_PHASE = 2'd3;

    localparam logic [7:0] CTRL_OFS = 8'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2
    } corr_state_t;

    // Magnitude and phase use the narrower correction width; DC offsets use the wide one.
    function automatic logic isCorrCh(input logic [1:0] ch);
        case (ch)
            CH_IDCO, CH_QDCO: isCorrCh = 1'b0;
            CH_MAG, CH_PHASE: isCorrCh = 1'b1;
            default:          isCorrCh = 1'b0;
        endcase
    endfunction

    // First pending channel at or after ptr, wrapping 3 -> 0.
    function automatic logic [1:0] rrPick(input logic [NUM_CH-1:0] pend, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rrPick = ptr;
        found  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ptr + 2'(i);
            if (!found && pend[idx]) begin
                rrPick = idx;
                found  = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/tx_corr_sched_if.sv
// Settings-bus bundle: host-side write port in, downstream write port and busy flag out.
interface tx_corr_sched_if;

    logic        in_stb;
    logic [7:0]  in_addr;
    logic [31:0] in_data;
    logic        out_stb;
    logic [7:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;

    modport master (
        output in_stb, in_addr, in_data,
        input  out_stb, out_addr, out_data, busy
    );

    modport slave (
        input  in_stb, in_addr, in_data,
        output out_stb, out_addr, out_data, busy
    );

endinterface

// File: rtl/tx_corr_step.sv
// Next value for one correction channel: move current toward target by at most
// step, landing exactly on target (step of zero means jump straight there).
module tx_corr_step #(
    parameter int DCO_W = 24
) (
    input  logic signed [DCO_W:0] i_current,
    input  logic signed [DCO_W:0] i_target,
    input  logic [15:0]           i_step,
    output logic signed [DCO_W:0] o_next
);

    logic signed [DCO_W:0] w_diff;
    logic        [DCO_W:0] w_absDiff;
    logic        [DCO_W:0] w_stepExt;

    // Operands stay inside the channel width, so the difference cannot overflow DCO_W+1 bits.
    always_comb begin
        w_diff    = i_target - i_current;
        w_absDiff = w_diff[DCO_W] ? -w_diff : w_diff;
        w_stepExt = {{(DCO_W + 1 - 16){1'b0}}, i_step};
        if (i_step == 16'd0 || w_absDiff <= w_stepExt) begin
            o_next = i_target;
        end else if (w_diff[DCO_W]) begin
            o_next = i_current - signed'(w_stepExt);
        end else begin
            o_next = i_current + signed'(w_stepExt);
        end
    end

endmodule

// File: rtl/tx_corr_sched.sv
// Correction-register scheduler in front of tx_frontend. Ramping (tick counter and
// step size) is built only when TX_CORR_RAMP_EN is defined; otherwise each target write jumps.
module tx_corr_sched
    import tx_corr_pkg::*;
#(
    parameter logic [7:0] BASE   = 8'd0,
    parameter int         DCO_W  = 24,
    parameter int         CORR_W = 18
) (
    input  logic           clk,
    input  logic           rst,
    tx_corr_sched_if.slave bus
);

    localparam int VW = DCO_W + 1;
    typedef logic signed [VW-1:0] val_t;

    val_t              r_target  [NUM_CH];
    val_t              r_current [NUM_CH];
    logic [NUM_CH-1:0] r_pending;
    logic [1:0]        r_ptr;
    logic [1:0]        r_sel;
    corr_state_t       r_state;
    logic              r_outStb;
    logic [7:0]        r_outAddr;
    logic [31:0]       r_outData;
    logic              r_busy;

    logic [7:0]        w_ofs;
    logic              w_isCorr;
    logic              w_isCtrl;
    logic              w_fwd;
    logic              w_fire;
    val_t              w_hostVal;
    val_t              w_next;
    val_t              w_curNext [NUM_CH];
    val_t              w_tgtNext [NUM_CH];
    logic [NUM_CH-1:0] w_pendNext;
    logic              w_busyNext;
    logic [15:0]       w_step;

`ifdef TX_CORR_RAMP_EN
    logic [15:0] r_interval;
    logic [15:0] r_step;
    logic [15:0] r_tickCnt;
    logic        w_tick;

    assign w_tick = (r_tickCnt == r_interval);
    assign w_step = r_step;

    // A control write restarts the tick phase so the new interval starts cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_interval <= 16'd0;
            r_step     <= 16'd0;
            r_tickCnt  <= 16'd0;
        end else if (w_isCtrl) begin
            r_interval <= bus.in_data[15:0];
            r_step     <= bus.in_data[31:16];
            r_tickCnt  <= 16'd0;
        end else if (w_tick) begin
            r_tickCnt  <= 16'd0;
        end else begin
            r_tickCnt  <= r_tickCnt + 16'd1;
        end
    end
`else
    assign w_step = 16'd0;
`endif

    assign w_ofs    = bus.in_addr - BASE;
    assign w_isCorr = bus.in_stb && (w_ofs < 8'd4);
    assign w_isCtrl = bus.in_stb && (w_ofs == CTRL_OFS);
    assign w_fwd    = bus.in_stb && !w_isCorr && !w_isCtrl;
    assign w_fire   = (r_state == ISSUE) && !bus.in_stb;

    assign w_hostVal = isCorrCh(w_ofs[1:0])
        ? {{(VW - CORR_W){bus.in_data[CORR_W-1]}}, bus.in_data[CORR_W-1:0]}
        : {bus.in_data[DCO_W-1], bus.in_data[DCO_W-1:0]};

    tx_corr_step #(.DCO_W(DCO_W)) u_step (
        .i_current (r_current[r_sel]),
        .i_target  (r_target[r_sel]),
        .i_step    (w_step),
        .o_next    (w_next)
    );

    // Pending evaluation uses the post-write current so a finishing channel is not re-armed.
    always_comb begin
        w_pendNext = r_pending;
        w_busyNext = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_curNext[c] = (w_fire && r_sel == 2'(c)) ? w_next : r_current[c];
            w_tgtNext[c] = (w_isCorr && w_ofs[1:0] == 2'(c)) ? w_hostVal : r_target[c];
            if (w_curNext[c] != w_tgtNext[c]) begin
                w_busyNext = 1'b1;
            end
        end
        if (w_fire) begin
            w_pendNext[r_sel] = 1'b0;
        end
`ifdef TX_CORR_RAMP_EN
        if (w_tick) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_curNext[c] != r_target[c]) begin
                    w_pendNext[c] = 1'b1;
                end
            end
        end
`else
        if (w_isCorr) begin
            w_pendNext[w_ofs[1:0]] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_sel     <= 2'd0;
            r_ptr     <= 2'd0;
            r_pending <= '0;
            r_outStb  <= 1'b0;
            r_outAddr <= 8'd0;
            r_outData <= 32'd0;
            r_busy    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_target[c]  <= '0;
                r_current[c] <= '0;
            end
        end else begin
            r_pending <= w_pendNext;
            r_busy    <= w_busyNext;
            for (int c = 0; c < NUM_CH; c++) begin
                r_target[c]  <= w_tgtNext[c];
                r_current[c] <= w_curNext[c];
            end

            r_outStb <= 1'b0;
            if (w_fwd) begin
                r_outStb  <= 1'b1;
                r_outAddr <= bus.in_addr;
                r_outData <= bus.in_data;
            end else if (w_fire) begin
                r_outStb  <= 1'b1;
                r_outAddr <= BASE + {6'd0, r_sel};
                r_outData <= {{(32 - VW){w_next[VW-1]}}, w_next};
            end

            // Host traffic always wins: ISSUE only completes in a cycle without a host strobe.
            case (r_state)
                IDLE: begin
                    if (|r_pending) begin
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_sel   <= rrPick(r_pending, r_ptr);
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    if (w_fire) begin
                        r_ptr   <= r_sel + 2'd1;
                        r_state <= (|w_pendNext) ? SCAN : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_stb  = r_outStb;
    assign bus.out_addr = r_outAddr;
    assign bus.out_data = r_outData;
    assign bus.busy     = r_busy;

endmodule
